// File: rtl/spi_cmd_if.sv
// Bus bundle between the SPI pins and the register bank: serial inputs and the decoded command outputs.
interface spi_cmd_if #(
  parameter int BYTE_CNT_W = 8
) ();
  logic                  cs;
  logic                  pico_spi;
  logic                  is_write;
  logic [6:0]            addr;
  logic                  addr_valid;
  logic [7:0]            wdata;
  logic                  wdata_valid;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic                  frame_err;

  modport master (
    output cs, pico_spi,
    input  is_write, addr, addr_valid, wdata, wdata_valid, byte_count, frame_err
  );

  modport slave (
    input  cs, pico_spi,
    output is_write, addr, addr_valid, wdata, wdata_valid, byte_count, frame_err
  );
endinterface

// File: rtl/spi_cmd_deserializer.sv
// SPI slave command front end: shifts PICO in on spi_clk, decodes the R/W + address byte,
// then presents each following byte as wdata with a one-cycle strobe in write frames.
module spi_cmd_deserializer #(
  parameter int NUM_ADDR   = 10,
  parameter int BYTE_CNT_W = 8
) (
  input  logic     spi_clk_i,
  input  logic     rstn_i,
  spi_cmd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [6:0] MAX_ADDR = 7'(NUM_ADDR);

  // Dropping chip select clears the whole frame asynchronously, like a reset.
  logic frame_rst_n;
  assign frame_rst_n = rstn_i & bus.cs;

  state_t                state_q, state_d;
  logic [6:0]            sr_q, sr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  is_write_q, is_write_d;
  logic [6:0]            addr_q, addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  wdata_valid_q, wdata_valid_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  mid_byte_q, mid_byte_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            full_byte;

  // Only seven history bits are kept: the eighth bit of a byte is the live PICO sample.
  assign full_byte = {sr_q, bus.pico_spi};

  always_comb begin
    state_d       = state_q;
    sr_d          = full_byte[6:0];
    bit_cnt_d     = bit_cnt_q + 3'd1;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    addr_valid_d  = addr_valid_q;
    wdata_d       = wdata_q;
    wdata_valid_d = 1'b0;
    byte_cnt_d    = byte_cnt_q;
    mid_byte_d    = (bit_cnt_d != 3'd0);
    frame_err_d   = frame_err_q | ((state_q == IDLE) & mid_byte_q);

    case (state_q)
      IDLE: state_d = ADDR;
      ADDR: begin
        if (bit_cnt_q == 3'd7) begin
          state_d      = DATA;
          is_write_d   = full_byte[7];
          addr_d       = full_byte[6:0];
          addr_valid_d = (full_byte[6:0] != 7'd0) && (full_byte[6:0] <= MAX_ADDR);
        end
      end
      DATA: begin
        if (bit_cnt_q == 3'd7) begin
          wdata_d       = full_byte;
          wdata_valid_d = is_write_q;
          if (byte_cnt_q != {BYTE_CNT_W{1'b1}}) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      addr_valid_q  <= 1'b0;
      wdata_q       <= '0;
      wdata_valid_q <= 1'b0;
      byte_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      is_write_q    <= is_write_d;
      addr_q        <= addr_d;
      addr_valid_q  <= addr_valid_d;
      wdata_q       <= wdata_d;
      wdata_valid_q <= wdata_valid_d;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

  // Survives chip select so the next frame can report that the previous one was truncated.
  always_ff @(posedge spi_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mid_byte_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (bus.cs) begin
      mid_byte_q  <= mid_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.is_write    = is_write_q;
  assign bus.addr        = addr_q;
  assign bus.addr_valid  = addr_valid_q;
  assign bus.wdata       = wdata_q;
  assign bus.wdata_valid = wdata_valid_q;
  assign bus.byte_count  = byte_cnt_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_cmd_deserializer.sv
// Self-checking bench: directed frame table, hand-written abort/reset/saturation sequences,
// and random frames, all checked every edge against a bit-queue reference model.
module tb_spi_cmd_deserializer;

  localparam int NUM_ADDR = 10;
  localparam int BCW      = 8;

  typedef struct packed {
    logic       is_write;
    logic [6:0] addr;
    logic       addr_valid;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic [7:0] byte_count;
    logic       frame_err;
  } outs_t;

  typedef struct {
    logic [7:0]  b0;
    logic [23:0] data;
    int          nd;
    logic        e_w;
    logic [6:0]  e_addr;
    logic        e_av;
    logic [7:0]  e_wdata;
    logic        e_wv;
    logic [7:0]  e_bc;
  } vec_t;

  logic spi_clk = 1'b0;
  logic rstn;
  spi_cmd_if #(.BYTE_CNT_W(BCW)) bus ();

  spi_cmd_deserializer #(.NUM_ADDR(NUM_ADDR), .BYTE_CNT_W(BCW)) dut (
    .spi_clk_i (spi_clk),
    .rstn_i    (rstn),
    .bus       (bus)
  );

  always #5 spi_clk = ~spi_clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: every bit of the current frame, plus sticky error state.
  bit fbits[$];
  bit m_err;
  bit m_partial;

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], logic'(fbits[8*k+i])};
    return v;
  endfunction

  function automatic outs_t model_outs();
    outs_t      o = '0;
    int         n = fbits.size();
    int         nb;
    logic [7:0] b0 = '0;
    o.frame_err = m_err;
    if (n >= 8) begin
      b0           = byte_at(0);
      o.is_write   = b0[7];
      o.addr       = b0[6:0];
      o.addr_valid = (int'(b0[6:0]) >= 1) && (int'(b0[6:0]) <= NUM_ADDR);
    end
    nb = n / 8 - 1;
    if (nb >= 1) begin
      o.wdata       = byte_at(nb);
      o.byte_count  = (nb > 255) ? 8'hFF : 8'(nb);
      o.wdata_valid = ((n % 8) == 0) && b0[7];
    end
    return o;
  endfunction

  function automatic outs_t dut_outs();
    return {bus.is_write, bus.addr, bus.addr_valid, bus.wdata,
            bus.wdata_valid, bus.byte_count, bus.frame_err};
  endfunction

  task automatic m_reset();
    fbits.delete();
    m_err     = 1'b0;
    m_partial = 1'b0;
  endtask

  task automatic check(input string name);
    outs_t e = model_outs();
    outs_t a = dut_outs();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s (edge %0d): got %h expected %h", name, fbits.size(), a, e);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic do_edge(input bit b);
    bus.pico_spi = b;
    @(posedge spi_clk);
    if (fbits.size() == 0 && m_partial) m_err = 1'b1;
    fbits.push_back(b);
    m_partial = (fbits.size() % 8) != 0;
    @(negedge spi_clk);
    check("edge");
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) do_edge(b[i]);
  endtask

  task automatic start_frame();
    bus.cs = 1'b1;
    #1;
    check("cs_rise");
  endtask

  task automatic end_frame();
    bus.cs = 1'b0;
    #1;
    fbits.delete();
    check("cs_fall");
    @(negedge spi_clk);
  endtask

  task automatic pulse_rstn();
    rstn = 1'b0;
    #1;
    m_reset();
    check("rstn_async");
    bus.cs = 1'b0;
    @(negedge spi_clk);
    rstn = 1'b1;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h82, 24'hA50000, 1, 1'b1, 7'd2,  1'b1, 8'hA5, 1'b1, 8'd1};
    tbl[1] = '{8'h0A, 24'hFF0000, 1, 1'b0, 7'd10, 1'b1, 8'hFF, 1'b0, 8'd1};
    tbl[2] = '{8'h85, 24'h3CC30F, 3, 1'b1, 7'd5,  1'b1, 8'h0F, 1'b1, 8'd3};
    tbl[3] = '{8'h80, 24'h550000, 1, 1'b1, 7'd0,  1'b0, 8'h55, 1'b1, 8'd1};
    tbl[4] = '{8'h8B, 24'h550000, 1, 1'b1, 7'd11, 1'b0, 8'h55, 1'b1, 8'd1};

    rstn = 1'b0;
    bus.cs = 1'b0;
    bus.pico_spi = 1'b0;
    m_reset();
    @(negedge spi_clk);
    @(negedge spi_clk);
    check("reset");
    rstn = 1'b1;
    @(negedge spi_clk);

    for (int t = 0; t < 5; t++) begin
      outs_t e;
      start_frame();
      send_byte(tbl[t].b0);
      check_val("after_addr_wdata", 32'(bus.wdata), 32'h0);
      for (int j = 0; j < tbl[t].nd; j++) send_byte(tbl[t].data[23-8*j -: 8]);
      e = {tbl[t].e_w, tbl[t].e_addr, tbl[t].e_av, tbl[t].e_wdata,
           tbl[t].e_wv, tbl[t].e_bc, 1'b0};
      vectors++;
      if (dut_outs() !== e) begin
        miscompares++;
        $display("FAIL table[%0d]: got %h expected %h", t, dut_outs(), e);
      end
      end_frame();
      $display("frame table[%0d]: first=%h data=%h bytes=%0d", t, tbl[t].b0, tbl[t].data, tbl[t].nd);
    end

    // Aborted frame sets the sticky error on the next frame's first edge.
    start_frame();
    send_byte(8'h83);
    for (int i = 0; i < 4; i++) do_edge(1'b1);
    end_frame();
    check_val("abort_no_err_yet", 32'(bus.frame_err), 32'h0);
    start_frame();
    do_edge(1'b1);
    check_val("frame_err_set", 32'(bus.frame_err), 32'h1);
    for (int i = 0; i < 7; i++) do_edge(1'b0);
    send_byte(8'h12);
    end_frame();
    start_frame();
    send_byte(8'h84);
    send_byte(8'h99);
    end_frame();
    check_val("frame_err_sticky", 32'(bus.frame_err), 32'h1);
    pulse_rstn();
    check_val("frame_err_cleared", 32'(bus.frame_err), 32'h0);
    $display("frame abort: 12 edges then cs low, sticky error checked");

    // Reset asserted at edge 20 of a write frame.
    start_frame();
    send_byte(8'h83);
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) do_edge(1'b1);
    pulse_rstn();
    $display("frame rstn_mid: reset at edge 20");

    // Byte counter saturation.
    start_frame();
    send_byte(8'h81);
    for (int k = 0; k < 300; k++) send_byte(8'($urandom));
    check_val("byte_count_sat", 32'(bus.byte_count), 32'hFF);
    end_frame();
    $display("frame saturate: 300 data bytes");

    // Random frames, occasionally truncated or cut by reset.
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(0, 40);
      start_frame();
      for (int i = 0; i < n; i++) do_edge(1'($urandom));
      if ($urandom_range(0, 7) == 0) pulse_rstn();
      else end_frame();
      $display("frame random[%0d]: %0d edges, frame_err=%0b", f, n, bus.frame_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
